// File: rtl/fft_stage_collector.sv
// fft_stage_collector
// Gathers the time-multiplexed lane results of one butterfly/MAC column into a
// full N-point frame of complex words ([63:32] real float, [31:0] imag float)
// and hands it downstream over a valid/ready handshake. One capture buffer
// plus one output register let capture of the next frame overlap the wait on
// the current one. Data is passed bit-exact.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   lane data and in_slot valid this cycle
//   in_ready   collector can accept a slot this cycle
//   in_slot    slot index of the current lane data
//   lane_lo    lane k low-half result at [k*W +: W]
//   lane_hi    lane k high-half result at [k*W +: W]
//   out_valid  outmac holds a complete frame
//   out_ready  downstream accepts the frame
//   outmac     point i at [i*W +: W]
//   frame_cnt  frames delivered, wraps 255 -> 0
//   slot_err   sticky flag: duplicate slot seen within one frame
module fft_stage_collector #(
    parameter int unsigned LANES = 4,
    parameter int unsigned SLOTS = 4,
    parameter int unsigned W     = 64,
    localparam int unsigned N    = 2 * LANES * SLOTS,
    localparam int unsigned SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      in_slot,
    input  logic [LANES*W-1:0] lane_lo,
    input  logic [LANES*W-1:0] lane_hi,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*W-1:0]     outmac,
    output logic [7:0]         frame_cnt,
    output logic               slot_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]       state;
    logic [W-1:0]     cap [N];
    logic [SLOTS-1:0] mask;
    logic [SLOTS-1:0] mask_set;
    logic             accept;
    logic             transfer;

    assign in_ready = (state == S_FILL);
    assign accept   = in_valid && in_ready;
    // The output register can be (re)loaded when empty or when its current
    // frame is consumed on this same edge, giving back-to-back frames.
    assign transfer = (state == S_FULL) && (!out_valid || out_ready);

    always_comb begin
        mask_set = mask | (SLOTS'(1) << in_slot);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                cap[i] <= '0;
            end
            mask      <= '0;
            state     <= S_FILL;
            outmac    <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
            slot_err  <= 1'b0;
        end else begin
            if (accept) begin
                // Lane k low half lands in the first half of the frame, high
                // half in the second; slot selects the point within the lane.
                for (int unsigned k = 0; k < LANES; k++) begin
                    cap[IW'(k*SLOTS + 32'(in_slot))]             <= lane_lo[k*W +: W];
                    cap[IW'(LANES*SLOTS + k*SLOTS + 32'(in_slot))] <= lane_hi[k*W +: W];
                end
                // A duplicate overwrites data but leaves the mask unchanged.
                if (mask[in_slot]) begin
                    slot_err <= 1'b1;
                end
                mask <= mask_set;
                if (&mask_set) begin
                    state <= S_FULL;
                end
            end

            if (transfer) begin
                for (int unsigned i = 0; i < N; i++) begin
                    outmac[i*W +: W] <= cap[i];
                end
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
                mask      <= '0;
                state     <= S_FILL;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fft_stage_collector.md
Name: fft_stage_collector

Overview:
- Receive end of the time-multiplexed butterfly/MAC column interface. Each cycle, every MAC lane presents one low-half result and one high-half result tagged with a 2-bit slot number.
- The block gathers all slots of one column into a full 32-point frame (64-bit complex words: [63:32] real float, [31:0] imag float).
- It then hands the packed frame to the next column or the output stage over a valid/ready handshake.
- One capture buffer plus one output register, so capture of frame N+1 overlaps the wait on frame N.

Parameters:
- LANES, 4, number of MAC lanes feeding the collector
- SLOTS, 4, time slots per frame (slot field width = clog2(SLOTS))
- W, 64, complex word width
- N, 2*LANES*SLOTS (=32), points per frame (derived; not overridable)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  lane data and in_slot are valid this cycle
- in_ready  out  1  collector can accept a slot this cycle
- in_slot  in  2  slot index of the current lane data (the MAC select count)
- lane_lo  in  LANES*W  lane k low-half result at [k*W +: W]
- lane_hi  in  LANES*W  lane k high-half result at [k*W +: W]
- out_valid  out  1  outmac holds a complete frame
- out_ready  in  1  downstream accepts the frame
- outmac  out  N*W  point i at [i*W +: W]
- frame_cnt  out  8  frames delivered, wraps 255->0
- slot_err  out  1  sticky: a duplicate slot was received within one frame

Behaviour:
- Reset (async assert, sync release): capture buffer = 0, slot mask = 0, outmac = 0, out_valid = 0, frame_cnt = 0, slot_err = 0. in_ready = 1 after reset.
- Accept: a slot is accepted when in_valid && in_ready at the rising edge.
- Index mapping for accepted slot s and lane k:
  - lane_lo[k] -> cap[k*SLOTS + s]
  - lane_hi[k] -> cap[LANES*SLOTS + k*SLOTS + s]
  - Default map: lane0 -> points 0-3 and 16-19; lane3 -> points 12-15 and 28-31.
- Slot mask: bit s is set on accept.
- Duplicate slot (mask bit already set): data overwrites the previous entries, mask is unchanged, slot_err is set and stays set until reset.
- States:
  - FILL: mask not all-ones. in_ready = 1.
  - FULL: mask all-ones. in_ready = 0.
  - FILL->FULL on the edge that sets the last mask bit. Slots may arrive in any order.
- Transfer: in FULL, when (!out_valid || out_ready):
  - outmac <= cap, out_valid <= 1, frame_cnt += 1, mask <= 0, go to FILL.
  - cap contents are retained, not cleared.
- Latency: last slot sampled at edge E -> outmac valid after edge E+1 (earliest). in_ready is low for at least the one cycle between E and E+1.
- Output handshake:
  - When out_valid && out_ready, the frame is consumed; out_valid drops next edge unless a transfer reloads it in that same edge (back-to-back frames, no bubble).
  - outmac is stable while out_valid && !out_ready.
- Backpressure: while FULL and out_valid && !out_ready, in_ready stays 0. Upstream holds or stalls its slot counter.
- in_valid while in_ready = 0: ignored, no state change, no error.
- Reset mid-frame: partial mask discarded, pending outmac dropped, frame_cnt cleared.
- Data is passed bit-exact; no arithmetic is done on the float fields.

Test Plan:
- Slots 0,1,2,3 on consecutive cycles, lane_lo[k] = {k,s,lo} pattern e.g. 64'h0000_0k0s_0000_0001, out_ready = 1 -> out_valid rises 1 cycle after slot 3. outmac[i] matches the mapping for all 32 points (point 17 = lane0 hi slot1). frame_cnt = 1.
- Out-of-order slots 3,0,2,1 -> identical frame to sequential order; slot_err = 0.
- Slot sequence 0,1,1,2,3 with the second slot-1 data = 64'h3f800000_00000000 -> slot_err = 1. Points 1 and 17 hold the second values. Frame completes after slot 3.
- out_ready = 0 for 10 cycles with two frames streamed: frame 1 held stable on outmac; frame 2 captured, then in_ready = 0. Raise out_ready -> frame 1 consumed; frame 2 appears the next edge with no bubble; frame_cnt = 2.
- Assert reset asynchronously after 2 slots of a frame while a prior frame waits on out_valid -> out_valid = 0 and frame_cnt = 0 immediately. A following full frame is delivered clean with no stale slots.
- Stream 256 back-to-back frames with out_ready = 1 -> frame_cnt wraps to 0; in_ready low exactly one cycle per frame.
